// File: rtl/lut_access_ctrl_if.sv
// Config, lookup and response channels of the VPI/VCI lookup-table controller.
interface lut_access_ctrl_if #(
    parameter int ASIZE  = 8,
    parameter int DWIDTH = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic              cfg_inv;
    logic [ASIZE-1:0]  cfg_addr;
    logic [DWIDTH-1:0] cfg_data;
    logic              lk_valid;
    logic              lk_ready;
    logic [ASIZE-1:0]  lk_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [ASIZE-1:0]  rsp_addr;
    logic [DWIDTH-1:0] rsp_data;

    modport master (
        output cfg_valid, cfg_inv, cfg_addr, cfg_data,
        output lk_valid, lk_addr, rsp_ready,
        input  cfg_ready, lk_ready,
        input  rsp_valid, rsp_hit, rsp_addr, rsp_data
    );

    modport slave (
        input  cfg_valid, cfg_inv, cfg_addr, cfg_data,
        input  lk_valid, lk_addr, rsp_ready,
        output cfg_ready, lk_ready,
        output rsp_valid, rsp_hit, rsp_addr, rsp_data
    );
endinterface

// File: rtl/lut_access_ctrl.sv
// Clocked owner of the VPI/VCI lookup table: config writes, registered lookups,
// post-reset valid-bit sweep and a saturating miss counter.
module lut_access_ctrl #(
    parameter int ASIZE  = 8,
    parameter int DWIDTH = 16,
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lut_access_ctrl_if.slave     bus,
    output logic                 busy,
    output logic [CNTW-1:0]      miss_cnt
);
    localparam int DEPTH = 1 << ASIZE;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_busy;
    logic               w_run;
    logic [ASIZE-1:0]   r_sweep;

    logic [DWIDTH-1:0]  r_mem [DEPTH];
    logic               r_vld [DEPTH];

    logic               r_rsp_valid;
    logic               r_rsp_hit;
    logic [ASIZE-1:0]   r_rsp_addr;
    logic [DWIDTH-1:0]  r_rsp_data;
    logic [CNTW-1:0]    r_miss_cnt;

    logic               w_cfg_acc;
    logic               w_lk_ready;
    logic               w_lk_acc;
    logic               w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_busy)
                r_sweep <= r_sweep + ASIZE'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_run       = 1'b0;
        unique case (r_state)
            INIT: begin
                w_busy = 1'b1;
                if (r_sweep == '1)
                    w_state_nxt = RUN;
            end
            RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign w_cfg_acc  = bus.cfg_valid && w_run;
    // Same-address config wins; the lookup retries once the write has landed.
    assign w_lk_ready = w_run
                      && !(bus.cfg_valid && (bus.cfg_addr == bus.lk_addr))
                      && (!r_rsp_valid || bus.rsp_ready);
    assign w_lk_acc   = bus.lk_valid && w_lk_ready;
    assign w_hit      = r_vld[bus.lk_addr];

    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_vld[r_sweep] <= 1'b0;
        end else if (w_cfg_acc) begin
            if (bus.cfg_inv) begin
                r_vld[bus.cfg_addr] <= 1'b0;
            end else begin
                r_vld[bus.cfg_addr] <= 1'b1;
                r_mem[bus.cfg_addr] <= bus.cfg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_miss_cnt  <= '0;
        end else begin
            if (w_lk_acc) begin
                r_rsp_valid <= 1'b1;
                r_rsp_hit   <= w_hit;
                r_rsp_addr  <= bus.lk_addr;
                r_rsp_data  <= w_hit ? r_mem[bus.lk_addr] : '0;
            end else if (r_rsp_valid && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (w_lk_acc && !w_hit && (r_miss_cnt != '1))
                r_miss_cnt <= r_miss_cnt + CNTW'(1);
        end
    end

    assign busy          = w_busy;
    assign miss_cnt      = r_miss_cnt;
    assign bus.cfg_ready = w_run;
    assign bus.lk_ready  = w_lk_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_addr  = r_rsp_addr;
    assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_lut_access_ctrl.sv
// Directed self-checking bench for lut_access_ctrl: init sweep, table vectors,
// back-pressure, mid-sweep reset and miss-counter saturation.
module tb_lut_access_ctrl;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [15:0] miss_cnt;
    logic       busy2;
    logic [3:0] miss_cnt2;

    int checks = 0;
    int errors = 0;

    lut_access_ctrl_if #(.ASIZE(8), .DWIDTH(16)) bus ();
    lut_access_ctrl_if #(.ASIZE(4), .DWIDTH(16)) bus2 ();

    lut_access_ctrl #(.ASIZE(8), .DWIDTH(16), .CNTW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .busy     (busy),
        .miss_cnt (miss_cnt)
    );

    lut_access_ctrl #(.ASIZE(4), .DWIDTH(16), .CNTW(4)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus2.slave),
        .busy     (busy2),
        .miss_cnt (miss_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic        ci;
        logic [7:0]  ca;
        logic [15:0] cd;
        logic        lv;
        logic [7:0]  la;
        logic        rr;
        logic        e_lkr;
        logic        e_rv;
        logic        e_hit;
        logic [7:0]  e_addr;
        logic [15:0] e_data;
        logic [15:0] e_miss;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic ci, input logic [7:0] ca,
                         input logic [15:0] cd, input logic lv,
                         input logic [7:0] la, input logic rr);
        bus.cfg_valid = cv;
        bus.cfg_inv   = ci;
        bus.cfg_addr  = ca;
        bus.cfg_data  = cd;
        bus.lk_valid  = lv;
        bus.lk_addr   = la;
        bus.rsp_ready = rr;
    endtask

    task automatic wait_init(input string name);
        int  n;
        logic bad;
        n   = 0;
        bad = 1'b0;
        while (busy && n < 300) begin
            if (bus.cfg_ready !== 1'b0 || bus.lk_ready !== 1'b0)
                bad = 1'b1;
            tick();
            n++;
        end
        chk({name, "_ready_low"}, 32'(bad), 32'd0);
        chk({name, "_len"}, 32'(n), 32'd256);
        chk({name, "_busy_off"}, 32'(busy), 32'd0);
        chk({name, "_cfg_ready"}, 32'(bus.cfg_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{0,0,8'h00,16'h0000,1,8'h10,1, 1,1,0,8'h10,16'h0000,16'd1};
        vecs[1] = '{1,0,8'h2A,16'hBEEF,0,8'h00,1, 1,0,0,8'h00,16'h0000,16'd1};
        vecs[2] = '{0,0,8'h00,16'h0000,1,8'h2A,1, 1,1,1,8'h2A,16'hBEEF,16'd1};
        vecs[3] = '{1,1,8'h2A,16'h0000,0,8'h00,1, 1,0,0,8'h00,16'h0000,16'd1};
        vecs[4] = '{0,0,8'h00,16'h0000,1,8'h2A,1, 1,1,0,8'h2A,16'h0000,16'd2};
        vecs[5] = '{1,0,8'h05,16'h1234,1,8'h05,1, 0,0,0,8'h00,16'h0000,16'd2};
        vecs[6] = '{0,0,8'h00,16'h0000,1,8'h05,1, 1,1,1,8'h05,16'h1234,16'd2};
        vecs[7] = '{1,0,8'h05,16'h4321,1,8'h06,1, 1,1,0,8'h06,16'h0000,16'd3};
        vecs[8] = '{0,0,8'h00,16'h0000,1,8'h05,1, 1,1,1,8'h05,16'h4321,16'd3};

        rst_n = 1'b0;
        drive(0, 0, 8'h00, 16'h0000, 0, 8'h00, 1);
        bus2.cfg_valid = 1'b0;
        bus2.cfg_inv   = 1'b0;
        bus2.cfg_addr  = '0;
        bus2.cfg_data  = '0;
        bus2.lk_valid  = 1'b0;
        bus2.lk_addr   = '0;
        bus2.rsp_ready = 1'b1;
        tick();
        tick();

        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        chk("rst_rsp_addr", 32'(bus.rsp_addr), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        chk("rst_lk_ready", 32'(bus.lk_ready), 32'd0);

        #3 rst_n = 1'b1;
        #1;
        wait_init("init1");

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].cv, vecs[i].ci, vecs[i].ca, vecs[i].cd,
                  vecs[i].lv, vecs[i].la, vecs[i].rr);
            #1;
            chk($sformatf("v%0d_lk_ready", i), 32'(bus.lk_ready),
                32'(vecs[i].e_lkr));
            tick();
            chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid),
                32'(vecs[i].e_rv));
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_hit", i), 32'(bus.rsp_hit),
                    32'(vecs[i].e_hit));
                chk($sformatf("v%0d_addr", i), 32'(bus.rsp_addr),
                    32'(vecs[i].e_addr));
                chk($sformatf("v%0d_data", i), 32'(bus.rsp_data),
                    32'(vecs[i].e_data));
            end
            chk($sformatf("v%0d_miss", i), 32'(miss_cnt), 32'(vecs[i].e_miss));
        end

        // Back-pressure: response for 0x05 must hold while lookup 0x2A waits.
        drive(0, 0, 8'h00, 16'h0000, 1, 8'h2A, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d_lk_ready", i), 32'(bus.lk_ready), 32'd0);
            tick();
            chk($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp%0d_addr", i), 32'(bus.rsp_addr), 32'h05);
            chk($sformatf("bp%0d_data", i), 32'(bus.rsp_data), 32'h4321);
            chk($sformatf("bp%0d_hit", i), 32'(bus.rsp_hit), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_lk_ready", 32'(bus.lk_ready), 32'd1);
        tick();
        chk("bp_reload_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_reload_addr", 32'(bus.rsp_addr), 32'h2A);
        chk("bp_reload_hit", 32'(bus.rsp_hit), 32'd0);
        chk("bp_reload_miss", 32'(miss_cnt), 32'd4);

        begin
            logic [7:0]  sa [4];
            logic [15:0] sm [4];
            sa[0] = 8'h05; sa[1] = 8'h2A; sa[2] = 8'h06; sa[3] = 8'h05;
            sm[0] = 16'd4; sm[1] = 16'd5; sm[2] = 16'd6; sm[3] = 16'd6;
            for (int i = 0; i < 4; i++) begin
                bus.lk_addr = sa[i];
                #1;
                chk($sformatf("st%0d_lk_ready", i), 32'(bus.lk_ready), 32'd1);
                tick();
                chk($sformatf("st%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
                chk($sformatf("st%0d_addr", i), 32'(bus.rsp_addr), 32'(sa[i]));
                chk($sformatf("st%0d_miss", i), 32'(miss_cnt), 32'(sm[i]));
            end
        end
        bus.lk_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Park a held response, then reset must clear it immediately.
        drive(0, 0, 8'h00, 16'h0000, 1, 8'h05, 0);
        tick();
        bus.lk_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_data", 32'(bus.rsp_data), 32'd0);
        chk("async_rst_miss", 32'(miss_cnt), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (100) tick();
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_init("init2");

        bus.lk_valid = 1'b1;
        bus.lk_addr  = 8'h05;
        tick();
        bus.lk_valid = 1'b0;
        chk("post_rst_valid", 32'(bus.rsp_valid), 32'd1);
        chk("post_rst_hit", 32'(bus.rsp_hit), 32'd0);
        chk("post_rst_data", 32'(bus.rsp_data), 32'd0);
        chk("post_rst_miss", 32'(miss_cnt), 32'd1);

        chk("sat_init_done", 32'(busy2), 32'd0);
        bus2.lk_addr  = 4'h3;
        bus2.lk_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("sat%0d_miss", i), 32'(miss_cnt2),
                32'((i + 1 > 15) ? 15 : i + 1));
        end
        bus2.lk_valid = 1'b0;
        tick();
        chk("sat_final", 32'(miss_cnt2), 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
